// File: rtl/spi_flash_bridge.sv
// Bridge between the Xillybus byte-pipe FIFOs and the configuration flash:
// executes host-written SPI mode-0 packets and returns captured MISO bytes.
module spi_flash_bridge #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       bus_clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_empty,
    output logic       in_rden,
    input  logic       in_open,
    output logic [7:0] out_data,
    output logic       out_wren,
    input  logic       out_full,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, HDR_RD, HDR_LAT, DAT_RD, DAT_LAT, OUT_WAIT,
        CS_SETUP, SHIFT, STORE, CS_HOLD, CS_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic       cs_n_q, cs_n_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic [7:0] out_data_q, out_data_d;
    logic       abort_q, abort_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [5:0] cnt_q, cnt_d;
    logic       rel_q, rel_d;
    logic       cap_q, cap_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] rx_q, rx_d;

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            out_data_q <= 8'h00;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            out_data_q <= out_data_d;
            abort_q    <= abort_d;
        end
    end

    // Datapath registers carry no reset; every path out of IDLE reloads them.
    always_ff @(posedge bus_clk) begin
        hcnt_q <= hcnt_d;
        bcnt_q <= bcnt_d;
        cnt_q  <= cnt_d;
        rel_q  <= rel_d;
        cap_q  <= cap_d;
        sh_q   <= sh_d;
        rx_q   <= rx_d;
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        out_data_d = out_data_q;
        abort_d    = abort_q | (!in_open && state_q != IDLE);
        hcnt_d     = hcnt_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        rel_d      = rel_q;
        cap_d      = cap_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (!in_open && !cs_n_q) begin
                    state_d = CS_HOLD;
                    hcnt_d  = DIV_LAST;
                end else if (in_open && !in_empty) begin
                    state_d = HDR_RD;
                end
            end
            HDR_RD: if (!in_empty) state_d = HDR_LAT;
            HDR_LAT: begin
                rel_d   = in_data[7];
                cap_d   = in_data[6];
                cnt_d   = in_data[5:0];
                state_d = DAT_RD;
            end
            DAT_RD: begin
                if (abort_q || !in_open) begin
                    state_d = CS_HOLD;
                    hcnt_d  = DIV_LAST;
                end else if (!in_empty) begin
                    state_d = DAT_LAT;
                end
            end
            DAT_LAT: begin
                sh_d   = in_data;
                mosi_d = in_data[7];
                sclk_d = 1'b0;
                bcnt_d = 3'd7;
                hcnt_d = DIV_LAST;
                if (cap_q && out_full) begin
                    state_d = OUT_WAIT;
                end else if (cs_n_q) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                end else begin
                    state_d = SHIFT;
                end
            end
            OUT_WAIT: begin
                if (!out_full) begin
                    hcnt_d = DIV_LAST;
                    if (cs_n_q) begin
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            CS_SETUP: begin
                if (hcnt_q == 8'd0) begin
                    state_d = SHIFT;
                    hcnt_d  = DIV_LAST;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end
            // Rising edge samples MISO; falling edge advances MOSI or ends the byte.
            SHIFT: begin
                if (hcnt_q != 8'd0) begin
                    hcnt_d = hcnt_q - 8'd1;
                end else begin
                    hcnt_d = DIV_LAST;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bcnt_q == 3'd0) begin
                            state_d = STORE;
                            if (cap_q) out_data_d = rx_q;
                        end else begin
                            bcnt_d = bcnt_q - 3'd1;
                            sh_d   = {sh_q[6:0], 1'b0};
                            mosi_d = sh_q[6];
                        end
                    end
                end
            end
            STORE: begin
                hcnt_d = DIV_LAST;
                if (abort_q || !in_open) begin
                    state_d = CS_HOLD;
                end else if (cnt_q != 6'd0) begin
                    cnt_d   = cnt_q - 6'd1;
                    state_d = DAT_RD;
                end else if (rel_q) begin
                    state_d = CS_HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            CS_HOLD: begin
                if (hcnt_q == 8'd0) begin
                    cs_n_d  = 1'b1;
                    state_d = CS_GAP;
                    hcnt_d  = DIV_LAST;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end
            CS_GAP: begin
                if (hcnt_q == 8'd0) state_d = IDLE;
                else hcnt_d = hcnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rden = 1'b0;
        if (state_q == HDR_RD) in_rden = !in_empty;
        else if (state_q == DAT_RD) in_rden = !in_empty && in_open && !abort_q;
        out_wren = (state_q == STORE) && cap_q;
        busy     = (state_q != IDLE);
    end

    assign out_data = out_data_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_flash_bridge.sv
// Bench for spi_flash_bridge: FIFO models, SPI flash/loopback model and
// MOSI/response scoreboards, driven by one task per scenario.
`timescale 1ns/1ps
module tb_spi_flash_bridge;
    localparam int CLK_DIV = 2;

    logic       bus_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_empty = 1'b1;
    logic       in_rden;
    logic       in_open = 1'b1;
    logic [7:0] out_data;
    logic       out_wren;
    logic       out_full = 1'b0;
    logic       spi_cs_n, spi_sclk, spi_mosi, spi_miso;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] cmd_q[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_resp[$];
    logic [7:0] flash_q[$];

    logic stall = 1'b0, loopback = 1'b1, allow_partial = 1'b0, rden_seen = 1'b0;
    int   cyc = 0;
    int   wren_cnt, rise_cnt, bytes_done, cs_rise_cnt, cs_fall_cnt;
    int   first_rden_cyc, first_rise_cyc, last_fall_cyc, cs_rise_cyc;
    logic prev_sclk = 1'b0, prev_cs = 1'b1;
    logic [7:0] mbyte = 8'h00, fbyte = 8'hFF, exp_b;
    int   mbits = 0;
    logic [2:0] fidx = 3'd0;

    spi_flash_bridge #(.CLK_DIV(CLK_DIV)) dut (
        .bus_clk(bus_clk), .rst(rst), .in_data(in_data), .in_empty(in_empty),
        .in_rden(in_rden), .in_open(in_open), .out_data(out_data), .out_wren(out_wren),
        .out_full(out_full), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .busy(busy)
    );

    always #5 bus_clk = ~bus_clk;

    assign spi_miso = loopback ? spi_mosi : fbyte[3'd7 - fidx];

    // Command FIFO model: data appears the cycle after a read strobe.
    always @(posedge bus_clk) begin
        if (rden_seen && cmd_q.size() > 0) in_data <= cmd_q.pop_front();
        in_empty <= (cmd_q.size() == 0) || stall;
    end

    always @(negedge bus_clk) begin
        cyc++;
        rden_seen = in_rden;
        if (in_rden) begin
            checks++;
            if (in_empty !== 1'b0) begin
                errors++;
                $display("FAIL rden_empty: in_rden=1 with in_empty=%0b, required in_empty=0", in_empty);
            end
            if (first_rden_cyc < 0) first_rden_cyc = cyc;
        end
        if (out_wren) begin
            wren_cnt++;
            checks++;
            if (out_full !== 1'b0) begin
                errors++;
                $display("FAIL wren_full: out_wren=1 with out_full=%0b, required out_full=0", out_full);
            end
            checks++;
            if (exp_resp.size() == 0) begin
                errors++;
                $display("FAIL resp_extra: got 0x%02h, required no response byte", out_data);
            end else begin
                exp_b = exp_resp.pop_front();
                if (out_data !== exp_b) begin
                    errors++;
                    $display("FAIL resp_data: got 0x%02h, required 0x%02h", out_data, exp_b);
                end
            end
        end
        if (spi_sclk) begin
            checks++;
            if (spi_cs_n !== 1'b0) begin
                errors++;
                $display("FAIL sclk_cs: sclk=1 with cs_n=%0b, required cs_n=0", spi_cs_n);
            end
        end
        if (prev_cs && !spi_cs_n) begin
            cs_fall_cnt++;
            mbits = 0;
            fidx  = 3'd0;
            fbyte = (flash_q.size() > 0) ? flash_q.pop_front() : 8'hFF;
        end
        if (!prev_cs && spi_cs_n) begin
            cs_rise_cnt++;
            cs_rise_cyc = cyc;
            if (!allow_partial) begin
                checks++;
                if (mbits != 0) begin
                    errors++;
                    $display("FAIL partial_byte: cs rose after %0d bits, required 0", mbits);
                end
            end
        end
        if (!prev_sclk && spi_sclk && !spi_cs_n) begin
            rise_cnt++;
            if (first_rise_cyc < 0) first_rise_cyc = cyc;
            mbyte = {mbyte[6:0], spi_mosi};
            mbits++;
            if (fidx == 3'd7) begin
                fidx  = 3'd0;
                fbyte = (flash_q.size() > 0) ? flash_q.pop_front() : 8'hFF;
            end else begin
                fidx = fidx + 3'd1;
            end
            if (mbits == 8) begin
                mbits = 0;
                bytes_done++;
                checks++;
                if (exp_mosi.size() == 0) begin
                    errors++;
                    $display("FAIL mosi_extra: got 0x%02h, required no byte", mbyte);
                end else begin
                    exp_b = exp_mosi.pop_front();
                    if (mbyte !== exp_b) begin
                        errors++;
                        $display("FAIL mosi_byte: got 0x%02h, required 0x%02h", mbyte, exp_b);
                    end
                end
            end
        end
        if (prev_sclk && !spi_sclk) last_fall_cyc = cyc;
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge bus_clk);
        #1;
    endtask

    task automatic clear_mon();
        wren_cnt = 0; rise_cnt = 0; bytes_done = 0; cs_rise_cnt = 0; cs_fall_cnt = 0;
        first_rden_cyc = -1; first_rise_cyc = -1; last_fall_cyc = -1; cs_rise_cyc = -1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        tick(2);
        while ((busy || cmd_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy || cmd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle", name, busy, cmd_q.size());
        end
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (exp_mosi.size() != 0) begin
            errors++;
            $display("FAIL %s_mosi_left: %0d bytes not seen, required 0", name, exp_mosi.size());
        end
        checks++;
        if (exp_resp.size() != 0) begin
            errors++;
            $display("FAIL %s_resp_left: %0d bytes not seen, required 0", name, exp_resp.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if ({spi_cs_n, spi_sclk, spi_mosi, in_rden, out_wren, busy, out_data} !== {6'b100000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: cs,sclk,mosi,rden,wren,busy,data=%b, required 10000000000000",
                     {spi_cs_n, spi_sclk, spi_mosi, in_rden, out_wren, busy, out_data});
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if ({spi_cs_n, spi_sclk, busy} !== 3'b100) begin
            errors++;
            $display("FAIL idle_state: cs,sclk,busy=%b, required 100", {spi_cs_n, spi_sclk, busy});
        end
    endtask

    task automatic test_single_byte();
        int d;
        clear_mon();
        loopback = 1'b1;
        exp_mosi.push_back(8'h9F);
        exp_resp.push_back(8'h9F);
        cmd_q.push_back(8'hC0);
        cmd_q.push_back(8'h9F);
        wait_done("single", 400);
        checks++;
        if (first_rise_cyc - first_rden_cyc != 4 + 2 * CLK_DIV) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, required %0d", first_rise_cyc - first_rden_cyc, 4 + 2 * CLK_DIV);
        end
        checks++;
        if (wren_cnt != 1 || bytes_done != 1 || rise_cnt != 8) begin
            errors++;
            $display("FAIL single_counts: wren=%0d bytes=%0d rises=%0d, required 1 1 8", wren_cnt, bytes_done, rise_cnt);
        end
        checks++;
        if (cs_fall_cnt != 1 || cs_rise_cnt != 1 || spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL single_cs: falls=%0d rises=%0d cs_n=%0b, required 1 1 1", cs_fall_cnt, cs_rise_cnt, spi_cs_n);
        end
        d = cs_rise_cyc - last_fall_cyc;
        checks++;
        if (d < CLK_DIV || d > CLK_DIV + 1) begin
            errors++;
            $display("FAIL single_hold: cs rose %0d cycles after last fall, required %0d..%0d", d, CLK_DIV, CLK_DIV + 1);
        end
        check_queues("single");
    endtask

    task automatic test_read_id();
        clear_mon();
        loopback = 1'b0;
        flash_q = '{8'h00, 8'hEF, 8'h40, 8'h18};
        exp_mosi = '{8'h9F, 8'h00, 8'h00, 8'h00};
        exp_resp = '{8'hEF, 8'h40, 8'h18};
        cmd_q = '{8'h00, 8'h9F, 8'hC2, 8'h00, 8'h00, 8'h00};
        wait_done("readid", 1000);
        checks++;
        if (cs_fall_cnt != 1 || cs_rise_cnt != 1) begin
            errors++;
            $display("FAIL readid_cs: falls=%0d rises=%0d, required 1 1", cs_fall_cnt, cs_rise_cnt);
        end
        checks++;
        if (wren_cnt != 3 || bytes_done != 4) begin
            errors++;
            $display("FAIL readid_counts: wren=%0d bytes=%0d, required 3 4", wren_cnt, bytes_done);
        end
        check_queues("readid");
        flash_q.delete();
        loopback = 1'b1;
    endtask

    task automatic test_out_full();
        int n, r0, rel;
        logic hi;
        clear_mon();
        exp_mosi = '{8'hA5, 8'h3C};
        exp_resp = '{8'hA5, 8'h3C};
        cmd_q = '{8'hC1, 8'hA5, 8'h3C};
        n = 0;
        while (wren_cnt < 1 && n < 400) begin
            tick(1);
            n++;
        end
        out_full = 1'b1;
        r0 = rise_cnt;
        hi = 1'b0;
        repeat (50) begin
            tick(1);
            if (spi_sclk) hi = 1'b1;
        end
        checks++;
        if (rise_cnt != r0 || hi || wren_cnt != 1) begin
            errors++;
            $display("FAIL full_stall: rises=%0d->%0d sclk_high=%0b wren=%0d, required frozen and wren=1", r0, rise_cnt, hi, wren_cnt);
        end
        first_rise_cyc = -1;
        rel = cyc;
        out_full = 1'b0;
        wait_done("full", 600);
        checks++;
        if (first_rise_cyc < 0 || first_rise_cyc - rel > 4 + CLK_DIV) begin
            errors++;
            $display("FAIL full_resume: first rise %0d cycles after release, required <= %0d", first_rise_cyc - rel, 4 + CLK_DIV);
        end
        checks++;
        if (wren_cnt != 2) begin
            errors++;
            $display("FAIL full_wren: got %0d writes, required 2", wren_cnt);
        end
        check_queues("full");
    endtask

    task automatic test_empty_stall();
        logic [7:0] pay[4];
        int n, r0;
        logic hi;
        pay = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        clear_mon();
        for (int i = 0; i < 4; i++) exp_mosi.push_back(pay[i]);
        cmd_q = '{8'h83, pay[0]};
        for (int i = 1; i < 4; i++) begin
            n = 0;
            while (bytes_done < i && n < 400) begin
                tick(1);
                n++;
            end
            tick(3 * CLK_DIV);
            r0 = rise_cnt;
            hi = 1'b0;
            stall = 1'b1;
            cmd_q.push_back(pay[i]);
            repeat (6) begin
                tick(1);
                if (spi_sclk) hi = 1'b1;
            end
            stall = 1'b0;
            checks++;
            if (rise_cnt != r0 || hi) begin
                errors++;
                $display("FAIL stall_%0d: rises=%0d->%0d sclk_high=%0b, required frozen low", i, r0, rise_cnt, hi);
            end
        end
        wait_done("stall", 600);
        checks++;
        if (bytes_done != 4 || wren_cnt != 0 || cs_rise_cnt != 1) begin
            errors++;
            $display("FAIL stall_counts: bytes=%0d wren=%0d cs_rises=%0d, required 4 0 1", bytes_done, wren_cnt, cs_rise_cnt);
        end
        check_queues("stall");
    endtask

    task automatic test_open_drop();
        int n, d;
        clear_mon();
        exp_mosi = '{8'h11, 8'h22};
        cmd_q = '{8'h84, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        n = 0;
        while (rise_cnt < 11 && n < 600) begin
            tick(1);
            n++;
        end
        in_open = 1'b0;
        n = 0;
        tick(1);
        while (busy && n < 400) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy || bytes_done != 2) begin
            errors++;
            $display("FAIL drop_done: busy=%0b bytes=%0d, required 0 2", busy, bytes_done);
        end
        checks++;
        if (cmd_q.size() != 3) begin
            errors++;
            $display("FAIL drop_unread: %0d bytes left in FIFO, required 3", cmd_q.size());
        end
        d = cs_rise_cyc - last_fall_cyc;
        checks++;
        if (spi_cs_n !== 1'b1 || d < CLK_DIV || d > CLK_DIV + 1) begin
            errors++;
            $display("FAIL drop_cs: cs_n=%0b hold=%0d, required 1 and %0d..%0d", spi_cs_n, d, CLK_DIV, CLK_DIV + 1);
        end
        check_queues("drop");
        cmd_q.delete();
        tick(3);
        in_open = 1'b1;
        tick(2);
    endtask

    task automatic test_rst_mid();
        int n;
        clear_mon();
        allow_partial = 1'b1;
        cmd_q = '{8'hC1, 8'hAA, 8'hBB};
        n = 0;
        while (rise_cnt < 4 && n < 400) begin
            tick(1);
            n++;
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({spi_cs_n, spi_sclk, busy, out_wren} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid: cs,sclk,busy,wren=%b, required 1000", {spi_cs_n, spi_sclk, busy, out_wren});
        end
        cmd_q.delete();
        tick(2);
        rst = 1'b0;
        tick(3);
        checks++;
        if (wren_cnt != 0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_noresp: wren=%0d data=0x%02h, required 0 0x00", wren_cnt, out_data);
        end
        mbits = 0;
        allow_partial = 1'b0;
        check_queues("rst");
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single_byte();
        test_read_id();
        test_out_full();
        test_empty_stall();
        test_open_drop();
        test_rst_mid();
        test_single_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end
endmodule
